// File: rtl/conv_job_scheduler_pkg.sv
// Shared types for the convolution job scheduler: FSM states, completion status, job descriptor.
package conv_sched_pkg;

  localparam int JOB_ID_W   = 8;
  localparam int JOB_ADDR_W = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } sched_state_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_TIMEOUT = 2'd1,
    ST_ABORTED = 2'd2
  } cmpl_status_e;

  // Descriptor widths follow the package constants; the top defaults its parameters to them.
  typedef struct packed {
    logic [JOB_ID_W-1:0]   id;
    logic [JOB_ADDR_W-1:0] base_addr;
  } job_desc_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/conv_job_scheduler_if.sv
// Host, controller and completion signals of the job scheduler bundled as one interface.
// Handshakes: a transfer happens on a rising clk edge where valid && ready; valid never waits on ready.
interface conv_job_scheduler_if #(
  parameter int LOG2_OF_MEM_HEIGHT = 20,
  parameter int ID_WIDTH           = 8,
  parameter int QUEUE_DEPTH        = 4
);
  logic                          job_valid;
  logic                          job_ready;
  logic [ID_WIDTH-1:0]           job_id;
  logic [LOG2_OF_MEM_HEIGHT-1:0] job_base_addr;
  logic                          abort;
  logic                          ctrl_start;
  logic                          ctrl_running;
  logic [LOG2_OF_MEM_HEIGHT-1:0] ctrl_base_addr;
  logic                          cmpl_valid;
  logic                          cmpl_ready;
  logic [ID_WIDTH-1:0]           cmpl_id;
  logic [31:0]                   cmpl_cycles;
  logic [1:0]                    cmpl_status;
  logic                          busy;
  logic [$clog2(QUEUE_DEPTH):0]  queue_level;

  modport master (
    output job_valid, job_id, job_base_addr, abort, ctrl_running, cmpl_ready,
    input  job_ready, ctrl_start, ctrl_base_addr, cmpl_valid, cmpl_id, cmpl_cycles,
           cmpl_status, busy, queue_level
  );

  modport slave (
    input  job_valid, job_id, job_base_addr, abort, ctrl_running, cmpl_ready,
    output job_ready, ctrl_start, ctrl_base_addr, cmpl_valid, cmpl_id, cmpl_cycles,
           cmpl_status, busy, queue_level
  );
endinterface

// File: rtl/conv_job_scheduler_fifo.sv
// Job descriptor FIFO: registered storage, head read straight from the array, flush clears pointers.
module sched_job_fifo
  import conv_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  arst_n_in,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  job_desc_t             din,
  output logic                  full,
  output logic                  empty,
  output logic [$clog2(DEPTH):0] level,
  output job_desc_t             head
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  job_desc_t          mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q;
  logic               do_push, do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the level says they were written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/conv_job_scheduler.sv
// Launches queued convolution jobs one at a time on the controller and reports a completion record per job.
module conv_job_scheduler
  import conv_sched_pkg::*;
#(
  parameter int LOG2_OF_MEM_HEIGHT = JOB_ADDR_W,
  parameter int QUEUE_DEPTH        = 4,
  parameter int ID_WIDTH           = JOB_ID_W,
  parameter int START_TIMEOUT      = 16
) (
  input  logic                clk,
  input  logic                arst_n_in,
  conv_job_scheduler_if.slave bus,
  output sched_state_e        dbg_state_o
);
  localparam int TMO_W = $clog2(START_TIMEOUT + 1);
  localparam int LVL_W = $clog2(QUEUE_DEPTH) + 1;

  sched_state_e                  state_q, state_d;
  cmpl_status_e                  status_q, status_d;
  logic [ID_WIDTH-1:0]           id_q, id_d;
  logic [LOG2_OF_MEM_HEIGHT-1:0] base_q, base_d;
  logic [31:0]                   cnt_q, cnt_d;
  logic [TMO_W-1:0]              tmo_q, tmo_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  job_desc_t        push_desc, head_desc;
  logic             start_c, cmpl_valid_c;

  assign bus.job_ready = !fifo_full && !bus.abort;
  assign fifo_push     = bus.job_valid && bus.job_ready;
  assign push_desc     = '{id: bus.job_id, base_addr: bus.job_base_addr};

  sched_job_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .flush     (bus.abort),
    .din       (push_desc),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .head      (head_desc)
  );

  always_comb begin
    state_d      = state_q;
    status_d     = status_q;
    id_d         = id_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    fifo_pop     = 1'b0;
    start_c      = 1'b0;
    cmpl_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          id_d     = head_desc.id;
          base_d   = head_desc.base_addr;
          status_d = ST_OK;
          cnt_d    = '0;
          tmo_d    = '0;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        start_c = !bus.ctrl_running;
        cnt_d   = sat_inc32(cnt_q);
        if (bus.ctrl_running) begin
          state_d = RUN;
        end else if (tmo_q == TMO_W'(START_TIMEOUT - 1)) begin
          status_d = ST_TIMEOUT;
          state_d  = REPORT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      RUN: begin
        cnt_d = sat_inc32(cnt_q);
        if (!bus.ctrl_running) state_d = REPORT;
      end
      REPORT: begin
        cmpl_valid_c = 1'b1;
        if (bus.cmpl_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A timeout decided in this same cycle outranks the abort; a finished handshake is left untouched.
    if (bus.abort && state_q != IDLE && status_d != ST_TIMEOUT &&
        !(state_q == REPORT && bus.cmpl_ready)) begin
      status_d = ST_ABORTED;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q  <= IDLE;
      status_q <= ST_OK;
      id_q     <= '0;
      base_q   <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      id_q     <= id_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.ctrl_start     = start_c;
  assign bus.ctrl_base_addr = base_q;
  assign bus.cmpl_valid     = cmpl_valid_c;
  assign bus.cmpl_id        = id_q;
  assign bus.cmpl_cycles    = cnt_q;
  assign bus.cmpl_status    = status_q;
  assign bus.busy           = (state_q != IDLE) || !fifo_empty;
  assign bus.queue_level    = fifo_level;
  assign dbg_state_o        = state_q;

endmodule
